// File: rtl/branch_predict_sched_if.sv
// rtl/branch_predict_sched_if.sv - fetch/execute handshake bundle for the branch predictor
interface branch_predict_sched_if #(
  parameter int IDX_W = 4,
  parameter int DEPTH = 8
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             lookup_valid;
  logic [IDX_W-1:0] lookup_idx;
  logic             lookup_ready;
  logic             pred_valid;
  logic             pred_taken;
  logic             resolve_valid;
  logic             resolve_taken;
  logic             mispredict;
  logic             resolve_err;
  logic             flush;
  logic [CNT_W-1:0] inflight_count;

  // fetch/execute side
  modport master (
    output lookup_valid, lookup_idx, resolve_valid, resolve_taken, flush,
    input  lookup_ready, pred_valid, pred_taken, mispredict, resolve_err, inflight_count
  );

  // predictor side
  modport slave (
    input  lookup_valid, lookup_idx, resolve_valid, resolve_taken, flush,
    output lookup_ready, pred_valid, pred_taken, mispredict, resolve_err, inflight_count
  );
endinterface

// File: rtl/branch_predict_sched.sv
// rtl/branch_predict_sched.sv - 2-bit counter branch predictor with in-order resolve queue
// Optional statistics counters are built when BP_STATS_EN is defined.
module branch_predict_sched #(
  parameter int IDX_W = 4,
  parameter int DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  branch_predict_sched_if.slave bus
`ifdef BP_STATS_EN
  ,
  output logic [15:0]           stat_resolved,
  output logic [15:0]           stat_mispred
`endif
);
  localparam int CNT_W   = $clog2(DEPTH) + 1;
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int ENTRIES = 2 ** IDX_W;

  logic [1:0]       cnt_q   [ENTRIES];
  logic [1:0]       cnt_d   [ENTRIES];
  logic [IDX_W-1:0] qidx_q  [DEPTH];
  logic [IDX_W-1:0] qidx_d  [DEPTH];
  logic             qpred_q [DEPTH];
  logic             qpred_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             pred_valid_q, pred_valid_d;
  logic             pred_taken_q, pred_taken_d;
  logic             mispredict_q, mispredict_d;
  logic             resolve_err_q, resolve_err_d;
`ifdef BP_STATS_EN
  logic [15:0]      stat_resolved_q, stat_resolved_d;
  logic [15:0]      stat_mispred_q, stat_mispred_d;
`endif

  logic             push;
  logic             pop;
  logic [IDX_W-1:0] head_idx;
  logic             head_pred;
  logic [1:0]       head_cnt;
  logic [1:0]       head_upd;
  logic [1:0]       look_cnt;

  // Readiness depends only on occupancy so a same-cycle pop never frees a slot early.
  assign bus.lookup_ready   = (count_q != CNT_W'(DEPTH));
  assign bus.pred_valid     = pred_valid_q;
  assign bus.pred_taken     = pred_taken_q;
  assign bus.mispredict     = mispredict_q;
  assign bus.resolve_err    = resolve_err_q;
  assign bus.inflight_count = count_q;
`ifdef BP_STATS_EN
  assign stat_resolved      = stat_resolved_q;
  assign stat_mispred       = stat_mispred_q;
`endif

  // Next-state: pop/update head counter, push lookup with write-first bypass, flush override.
  always_comb begin
    cnt_d         = cnt_q;
    qidx_d        = qidx_q;
    qpred_d       = qpred_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    pred_valid_d  = 1'b0;
    pred_taken_d  = pred_taken_q;
    mispredict_d  = 1'b0;
    resolve_err_d = 1'b0;
`ifdef BP_STATS_EN
    stat_resolved_d = stat_resolved_q;
    stat_mispred_d  = stat_mispred_q;
`endif

    pop  = bus.resolve_valid && (count_q != '0) && !bus.flush;
    push = bus.lookup_valid && bus.lookup_ready && !bus.flush;

    head_idx  = qidx_q[rd_ptr_q];
    head_pred = qpred_q[rd_ptr_q];
    head_cnt  = cnt_q[head_idx];
    if (bus.resolve_taken) begin
      head_upd = (head_cnt == 2'b11) ? 2'b11 : head_cnt + 2'd1;
    end else begin
      head_upd = (head_cnt == 2'b00) ? 2'b00 : head_cnt - 2'd1;
    end

    // A lookup hitting the entry being trained this cycle sees the trained value.
    look_cnt = (pop && (head_idx == bus.lookup_idx)) ? head_upd : cnt_q[bus.lookup_idx];

    if (pop) begin
      cnt_d[head_idx] = head_upd;
      rd_ptr_d        = rd_ptr_q + PTR_W'(1);
      mispredict_d    = (bus.resolve_taken != head_pred);
`ifdef BP_STATS_EN
      if (stat_resolved_q != 16'hFFFF) stat_resolved_d = stat_resolved_q + 16'd1;
      if (mispredict_d && (stat_mispred_q != 16'hFFFF)) stat_mispred_d = stat_mispred_q + 16'd1;
`endif
    end

    resolve_err_d = bus.resolve_valid && (count_q == '0) && !bus.flush;

    if (push) begin
      qidx_d[wr_ptr_q]  = bus.lookup_idx;
      qpred_d[wr_ptr_q] = look_cnt[1];
      wr_ptr_d          = wr_ptr_q + PTR_W'(1);
      pred_valid_d      = 1'b1;
      pred_taken_d      = look_cnt[1];
    end

    count_d = count_q + CNT_W'(push) - CNT_W'(pop);

    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  // State registers; reset returns every counter to strong-taken and empties the queue.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) cnt_q[i] <= 2'b11;
      for (int i = 0; i < DEPTH; i++) begin
        qidx_q[i]  <= '0;
        qpred_q[i] <= 1'b0;
      end
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      pred_valid_q  <= 1'b0;
      pred_taken_q  <= 1'b0;
      mispredict_q  <= 1'b0;
      resolve_err_q <= 1'b0;
`ifdef BP_STATS_EN
      stat_resolved_q <= '0;
      stat_mispred_q  <= '0;
`endif
    end else begin
      cnt_q         <= cnt_d;
      qidx_q        <= qidx_d;
      qpred_q       <= qpred_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      pred_valid_q  <= pred_valid_d;
      pred_taken_q  <= pred_taken_d;
      mispredict_q  <= mispredict_d;
      resolve_err_q <= resolve_err_d;
`ifdef BP_STATS_EN
      stat_resolved_q <= stat_resolved_d;
      stat_mispred_q  <= stat_mispred_d;
`endif
    end
  end
endmodule
